// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: WIDTH bits resolved in STAGES carry-chained
// chunks, one chunk per stage, with valid/ready flow control.
module pipe_adder #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be >=2 and divisible by STAGES");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    logic [WIDTH-1:0] a_o [STAGES];
    logic [WIDTH-1:0] b_o [STAGES];
    logic [WIDTH-1:0] s_o [STAGES];
    logic             c_o [STAGES];
    logic             o_o [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
        logic             c_i, v_i, cmsb, o_n;
        logic [CHUNK:0]   r;
        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic             v_q, c_q, o_q;

        if (k == 0) begin : g_head
            assign a_i = A;
            assign b_i = Sub ? ~B : B;
            assign c_i = Sub | Cin;
            assign s_i = '0;
            assign v_i = in_valid;
        end else begin : g_body
            assign a_i = a_o[k-1];
            assign b_i = b_o[k-1];
            assign c_i = c_o[k-1];
            assign s_i = s_o[k-1];
            assign v_i = v[k-1];
        end

        // A stage moves on if any later stage has a hole or the sink drains.
        if (k == STAGES - 1) begin : g_tail
            assign adv[k] = out_ready;
        end else begin : g_inner
            assign adv[k] = out_ready | ~(&v[STAGES-1:k+1]);
        end

        assign load[k] = ~v_q | adv[k];

        assign r = {1'b0, a_i[k*CHUNK +: CHUNK]}
                 + {1'b0, b_i[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_i};

        always_comb begin
            s_n = s_i;
            s_n[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
        end

        // Carry into the MSB recovered from the MSB sum bit.
        assign cmsb = a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ r[CHUNK-1];
        assign o_n  = cmsb ^ r[CHUNK];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                o_q <= 1'b0;
            end else if (load[k]) begin
                v_q <= v_i;
                a_q <= a_i;
                b_q <= b_i;
                s_q <= s_n;
                c_q <= r[CHUNK];
                o_q <= o_n;
            end
        end

        assign v[k]   = v_q;
        assign a_o[k] = a_q;
        assign b_o[k] = b_q;
        assign s_o[k] = s_q;
        assign c_o[k] = c_q;
        assign o_o[k] = o_q;
    end

    logic unused_tail;
    assign unused_tail = ^{a_o[STAGES-1], b_o[STAGES-1]};

    assign in_ready  = ~v[0] | adv[0];
    assign out_valid = v[STAGES-1];
    assign Sum       = s_o[STAGES-1];
    assign Cout      = c_o[STAGES-1];
    assign Ovf       = o_o[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised bench for pipe_adder: three configurations run side by side,
// each scored against an arithmetic reference model.
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 24 : 32;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;

        logic         rst_n;
        logic [W-1:0] a, b, sum;
        logic         cin, sub, in_valid, in_ready;
        logic         cout, ovf, out_valid, out_ready;
        bit           fin = 1'b0;

        logic [W+1:0] expq [$];
        int           cycq [$];

        pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .A         (a),
            .B         (b),
            .Cin       (cin),
            .Sub       (sub),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .Sum       (sum),
            .Cout      (cout),
            .Ovf       (ovf),
            .out_valid (out_valid),
            .out_ready (out_ready)
        );

        function automatic string tg(input string t);
            return $sformatf("w%0d.%s", W, t);
        endfunction

        // {ovf, cout, sum} from plain integer arithmetic.
        function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic c,
                                               input logic s);
            longint m, ux, uy, sx, sy, full, sg;
            logic co, ov;
            logic [W-1:0] rs;
            m  = longint'(1) << W;
            ux = longint'(x);
            uy = longint'(y);
            sx = x[W-1] ? ux - m : ux;
            sy = y[W-1] ? uy - m : uy;
            if (s) begin
                full = ux - uy;
                co   = (ux >= uy);
                sg   = sx - sy;
            end else begin
                full = ux + uy + longint'(c);
                co   = (full >= m);
                sg   = sx + sy + longint'(c);
            end
            ov = (sg < -(m / 2)) || (sg > (m / 2) - 1);
            rs = full[W-1:0];
            return {ov, co, rs};
        endfunction

        task automatic fire(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                            input logic tc, input logic ts,
                            input logic [W-1:0] es, input logic ec,
                            input logic eo, input string t);
            @(negedge clk);
            a = ta; b = tb2; cin = tc; sub = ts;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (S - 1) @(negedge clk);
            check(tg({t, ".valid"}), 64'(out_valid), 64'd1);
            check(tg({t, ".sum"}), 64'(sum), 64'(es));
            check(tg({t, ".cout"}), 64'(cout), 64'(ec));
            check(tg({t, ".ovf"}), 64'(ovf), 64'(eo));
        endtask

        task automatic run_phase(input int n, input int pv, input int pr,
                                 input bit latchk);
            int sent, cyc;
            bit hold, stl;
            logic [W+1:0] prev, e;
            sent = 0; cyc = 0; hold = 1'b0; stl = 1'b0; prev = '0;
            while (sent < n || expq.size() > 0) begin
                @(negedge clk);
                cyc++;
                if (cyc > n * 20 + 100) begin
                    check(tg("timeout"), 64'(expq.size()), 64'd0);
                    break;
                end
                if (!hold) begin
                    in_valid = (sent < n) && ($urandom_range(99) < pv);
                    a   = W'($urandom);
                    b   = W'($urandom);
                    cin = 1'($urandom);
                    sub = 1'($urandom);
                end
                out_ready = (sent >= n) || ($urandom_range(99) < pr);
                #1;
                check(tg("in_ready"), 64'(in_ready),
                      64'(!(expq.size() == S && !out_ready)));
                if (stl) begin
                    check(tg("stall.valid"), 64'(out_valid), 64'd1);
                    check(tg("stall.hold"), 64'({ovf, cout, sum}), 64'(prev));
                end
                if (out_valid && out_ready) begin
                    check(tg("pending"), 64'(expq.size() > 0), 64'd1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check(tg("sum"), 64'(sum), 64'(e[W-1:0]));
                        check(tg("cout"), 64'(cout), 64'(e[W]));
                        check(tg("ovf"), 64'(ovf), 64'(e[W+1]));
                        if (latchk)
                            check(tg("latency"), 64'(cyc - cycq[0]), 64'(S));
                        void'(cycq.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    expq.push_back(model(a, b, cin, sub));
                    cycq.push_back(cyc);
                    sent++;
                    hold = 1'b0;
                end else begin
                    hold = in_valid;
                end
                stl  = out_valid && !out_ready;
                prev = {ovf, cout, sum};
            end
            in_valid = 1'b0;
        endtask

        initial begin
            logic [W-1:0] maxp, minn;
            maxp = {1'b0, {(W-1){1'b1}}};
            minn = {1'b1, {(W-1){1'b0}}};
            rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'b1; sub = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check(tg("rst.valid"), 64'(out_valid), 64'd0);
            check(tg("rst.sum"), 64'(sum), 64'd0);
            check(tg("rst.flags"), 64'({cout, ovf}), 64'd0);
            rst_n = 1'b1; in_valid = 1'b0;
            @(negedge clk);
            #1;
            check(tg("rst.in_ready"), 64'(in_ready), 64'd1);

            fire('1, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0, "carry");
            fire(maxp, '1, 1'b0, 1'b1, minn, 1'b0, 1'b1, "subovf");
            fire(W'(5), W'(5), 1'b1, 1'b1, '0, 1'b1, 1'b0, "subeq");
            fire(maxp, '0, 1'b1, 1'b0, minn, 1'b0, 1'b1, "addovf");

            run_phase(100, 100, 100, 1'b1);
            run_phase(1000, 70, 50, 1'b0);

            out_ready = 1'b0;
            for (int i = 0; i < S + 5; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom);
                #1;
                if (!in_ready) break;
            end
            check(tg("full.in_ready"), 64'(in_ready), 64'd0);
            check(tg("full.valid"), 64'(out_valid), 64'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check(tg("midrst.valid"), 64'(out_valid), 64'd0);
            check(tg("midrst.out"), 64'({ovf, cout, sum}), 64'd0);
            expq.delete();
            cycq.delete();
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            run_phase(60, 70, 50, 1'b0);
            fin = 1'b1;
        end
    end

    initial begin
        wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end

endmodule
